// File: rtl/user_io_pkg.sv
// Shared definitions for the user I/O debouncer.
//   db_state_t       : per-channel debounce FSM states
//   deasserted_level : raw pin value that means "not pressed" for a polarity
//   cnt_width        : bits needed to hold a counter value 0..max_value
package user_io_pkg;

  typedef enum logic [1:0] {
    ST_LOW         = 2'd0,
    ST_SETTLE_HIGH = 2'd1,
    ST_HIGH        = 2'd2,
    ST_SETTLE_LOW  = 2'd3
  } db_state_t;

  // Idle pin level: pulled high when buttons short to ground (active low).
  function automatic logic deasserted_level(input int active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

  // Width for a counter that must reach max_value without wrapping.
  function automatic int cnt_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/user_io_debounce_channel.sv
// One debounced input channel.
//   clk        : clock
//   rst        : asynchronous active-high reset
//   pin        : raw asynchronous pin, may bounce
//   level      : debounced asserted state
//   pressed    : 1-cycle pulse when level rises
//   released   : 1-cycle pulse when level falls
//   long_press : 1-cycle pulse once level has been 1 for LONG_PRESS_CYCLES
module debounce_channel
  import user_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 600000,
  parameter int LONG_PRESS_CYCLES = 60000000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic pressed,
  output logic released,
  output logic long_press
);

  localparam logic IDLE_PIN = deasserted_level(ACTIVE_LOW);

  // Settle counter only has to reach DEBOUNCE_CYCLES-1; the hold counter
  // saturates at LONG_PRESS_CYCLES.
  localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic              sync_meta;
  logic              sync_out;
  logic              sample;
  db_state_t         state_reg,    state_next;
  logic [DEB_W-1:0]  deb_cnt_reg,  deb_cnt_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              pressed_reg,  pressed_next;
  logic              released_reg, released_next;
  logic              long_reg,     long_next;

  assign sample = (ACTIVE_LOW != 0) ? ~sync_out : sync_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta    <= IDLE_PIN;
      sync_out     <= IDLE_PIN;
      state_reg    <= ST_LOW;
      deb_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      pressed_reg  <= 1'b0;
      released_reg <= 1'b0;
      long_reg     <= 1'b0;
    end else begin
      sync_meta    <= pin;
      sync_out     <= sync_meta;
      state_reg    <= state_next;
      deb_cnt_reg  <= deb_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      pressed_reg  <= pressed_next;
      released_reg <= released_next;
      long_reg     <= long_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    deb_cnt_next  = deb_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    pressed_next  = 1'b0;
    released_next = 1'b0;
    long_next     = 1'b0;

    // Level is 1 in both HIGH and SETTLE_LOW, so hold time keeps
    // accumulating through a release glitch that later gets rejected.
    if ((state_reg == ST_HIGH || state_reg == ST_SETTLE_LOW) &&
        hold_cnt_reg != HOLD_MAX) begin
      hold_cnt_next = hold_cnt_reg + 1'b1;
      if (hold_cnt_reg == HOLD_LAST) begin
        long_next = 1'b1;
      end
    end

    case (state_reg)
      ST_LOW: begin
        if (sample) begin
          state_next   = ST_SETTLE_HIGH;
          deb_cnt_next = '0;
        end
      end
      ST_SETTLE_HIGH: begin
        if (!sample) begin
          state_next   = ST_LOW;
          deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next    = ST_HIGH;
          deb_cnt_next  = '0;
          hold_cnt_next = '0;
          pressed_next  = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt_reg + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!sample) begin
          state_next   = ST_SETTLE_LOW;
          deb_cnt_next = '0;
        end
      end
      ST_SETTLE_LOW: begin
        if (sample) begin
          state_next   = ST_HIGH;
          deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next    = ST_LOW;
          deb_cnt_next  = '0;
          hold_cnt_next = '0;
          released_next = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next   = ST_LOW;
        deb_cnt_next = '0;
      end
    endcase
  end

  assign level      = (state_reg == ST_HIGH) || (state_reg == ST_SETTLE_LOW);
  assign pressed    = pressed_reg;
  assign released   = released_reg;
  assign long_press = long_reg;

endmodule

// File: rtl/user_io_debounce.sv
// Multi-channel button debouncer with press/release/long-press events.
//   clk_60mhz  : single clock
//   rst        : asynchronous active-high reset
//   user_io    : raw asynchronous pins [WIDTH]
//   level      : debounced asserted state [WIDTH]
//   pressed    : rising-level pulses [WIDTH]
//   released   : falling-level pulses [WIDTH]
//   long_press : one pulse per long hold [WIDTH]
module user_io_debounce #(
  parameter int WIDTH             = 2,
  parameter int DEBOUNCE_CYCLES   = 600000,
  parameter int LONG_PRESS_CYCLES = 60000000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic             clk_60mhz,
  input  logic             rst,
  input  logic [WIDTH-1:0] user_io,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] released,
  output logic [WIDTH-1:0] long_press
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .ACTIVE_LOW       (ACTIVE_LOW)
    ) u_chan (
      .clk       (clk_60mhz),
      .rst       (rst),
      .pin       (user_io[gi]),
      .level     (level[gi]),
      .pressed   (pressed[gi]),
      .released  (released[gi]),
      .long_press(long_press[gi])
    );
  end

endmodule

// File: tb/tb_user_io_debounce.sv
module tb_user_io_debounce;

  localparam int W    = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int AL   = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] user_io = '1;
  logic [W-1:0] level, pressed, released, long_press;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  user_io_debounce #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG), .ACTIVE_LOW(AL)
  ) dut (
    .clk_60mhz(clk), .rst(rst), .user_io(user_io),
    .level(level), .pressed(pressed), .released(released), .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Behavioural reference: a pin value is seen by the decision logic two
  // edges after it is sampled; level flips once DEB+1 consecutive decision
  // edges disagree with it; long_press fires when level has stayed 1 for
  // exactly LONG edges.
  logic [W-1:0] m_level = '0, m_pressed = '0, m_released = '0, m_long = '0;
  logic [W-1:0] seen1 = '0, seen2 = '0;
  int run  [W];
  int hold [W];

  initial begin
    for (int c = 0; c < W; c++) begin run[c] = 0; hold[c] = 0; end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_level = '0; m_pressed = '0; m_released = '0; m_long = '0;
        seen1 = '0; seen2 = '0;
        for (int c = 0; c < W; c++) begin run[c] = 0; hold[c] = 0; end
      end else begin
        for (int c = 0; c < W; c++) begin
          m_pressed[c] = 1'b0; m_released[c] = 1'b0; m_long[c] = 1'b0;
          if (m_level[c]) begin
            hold[c]++;
            if (hold[c] == LONG) m_long[c] = 1'b1;
          end
          if (seen2[c] != m_level[c]) begin
            run[c]++;
            if (run[c] == DEB + 1) begin
              run[c] = 0;
              m_level[c] = seen2[c];
              if (seen2[c]) begin m_pressed[c] = 1'b1; hold[c] = 0; end
              else m_released[c] = 1'b1;
            end
          end else begin
            run[c] = 0;
          end
        end
        seen2 = seen1;
        seen1 = (AL != 0) ? ~user_io : user_io;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_level",    32'(level),      32'(m_level));
      chk("model_pressed",  32'(pressed),    32'(m_pressed));
      chk("model_released", 32'(released),   32'(m_released));
      chk("model_long",     32'(long_press), 32'(m_long));
      if ((pressed & released) != '0) chk("press_and_release", 32'(pressed & released), 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    step(2);
    check_en = 1'b1;
    chk("rst_level",    32'(level),      32'd0);
    chk("rst_pressed",  32'(pressed),    32'd0);
    chk("rst_released", 32'(released),   32'd0);
    chk("rst_long",     32'(long_press), 32'd0);
    #2 rst = 1'b0;
    step(10);

    // Clean press on channel 0
    #2 user_io[0] = 1'b0;
    step(6);  chk("clean_level_e5",   32'(level[0]),   32'd0);
    step(1);  chk("clean_level_e6",   32'(level[0]),   32'd1);
              chk("clean_pressed_e6", 32'(pressed[0]), 32'd1);
    step(1);  chk("clean_pressed_e7", 32'(pressed[0]), 32'd0);
    #2 user_io[0] = 1'b1;
    step(12); chk("clean_release_lvl", 32'(level[0]),  32'd0);

    // Bounce: 3 low, 1 high, then low
    #2 user_io[0] = 1'b0;
    step(3); #2 user_io[0] = 1'b1;
    step(1); #2 user_io[0] = 1'b0;
    step(6); chk("bounce_level_e5", 32'(level[0]),   32'd0);
    step(1); chk("bounce_level_e6", 32'(level[0]),   32'd1);
             chk("bounce_pressed",  32'(pressed[0]), 32'd1);
    #2 user_io[0] = 1'b1;
    step(12);

    // Long press: 40 cycles low
    #2 user_io[0] = 1'b0;
    step(7);  chk("long_rise",     32'(level[0]),      32'd1);
    step(19); chk("long_before",   32'(long_press[0]), 32'd0);
    step(1);  chk("long_pulse",    32'(long_press[0]), 32'd1);
    step(1);  chk("long_after",    32'(long_press[0]), 32'd0);
    step(12); #2 user_io[0] = 1'b1;
    step(6);  chk("long_rel_e5",   32'(released[0]),   32'd0);
    step(1);  chk("long_rel_e6",   32'(released[0]),   32'd1);
              chk("long_rel_lvl",  32'(level[0]),      32'd0);
    step(10);

    // Reset mid-settle, pin stays asserted
    #2 user_io[0] = 1'b0;
    step(5); #2 rst = 1'b1;
    step(2); chk("rstmid_pressed", 32'(pressed[0]), 32'd0);
    #2 rst = 1'b0;
    step(6); chk("rstmid_e5",     32'(pressed[0]), 32'd0);
    step(1); chk("rstmid_e6",     32'(pressed[0]), 32'd1);
    #2 user_io[0] = 1'b1;
    step(12);

    // Simultaneous press, then release channel 1 only
    #2 user_io = 2'b00;
    step(7); chk("simul_pressed", 32'(pressed), 32'd3);
    step(3); #2 user_io[1] = 1'b1;
    step(7); chk("simul_released", 32'(released), 32'd2);
             chk("simul_level",    32'(level),    32'd1);
    #2 user_io = 2'b11;
    step(12);

    // Randomised phase: alternating bouncy and calm stretches, rare resets
    for (int i = 0; i < 3000; i++) begin
      step(1);
      #2;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        step(2);
        #2 rst = 1'b0;
      end
      for (int c = 0; c < W; c++) begin
        if ($urandom_range(0, ((i / 200) % 2 == 0) ? 2 : 39) == 0)
          user_io[c] = ~user_io[c];
      end
    end
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
